// File: rtl/spike_event_queue.sv
// spike_event_queue: per-neuron rising-edge detector feeding a timestamped
// first-word-fall-through event FIFO with a valid/ready drain and a
// saturating drop counter for events lost to a full queue.
module spike_event_queue #(
   parameter  int ID_W  = 2,
   parameter  int TS_W  = 8,
   parameter  int DEPTH = 8,
   localparam int EV_W  = ID_W + TS_W,
   localparam int LVL_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             spike_in,
   input  logic [ID_W-1:0]  spike_id,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [EV_W-1:0]  out_data,
   output logic [LVL_W-1:0] level,
   output logic [7:0]       drop_cnt
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int N_ID  = 1 << ID_W;

   logic [TS_W-1:0]  r_ts;
   logic [N_ID-1:0]  r_prev;
   logic [EV_W-1:0]  r_mem [DEPTH];
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [LVL_W-1:0] r_level;
   logic [7:0]       r_drop;

   logic w_ev;
   logic w_full;
   logic w_empty;
   logic w_pop;
   logic w_push;
   logic w_drop;

   // A new event is a low-to-high transition of this neuron's sampled level.
   assign w_ev    = in_valid & spike_in & ~r_prev[spike_id];
   // Full/empty come from the occupancy count so wrapped pointers never alias.
   assign w_full  = (r_level == LVL_W'(DEPTH));
   assign w_empty = (r_level == '0);
   assign w_pop   = ~w_empty & out_ready;
   // A full queue still accepts an event when the head leaves in the same cycle.
   assign w_push  = w_ev & (~w_full | w_pop);
   assign w_drop  = w_ev & w_full & ~w_pop;

   // Timestamp, edge history, pointers, occupancy and drop counter.
   // NOTE: state registers use <= so every block sees pre-edge values regardless of evaluation order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ts     <= '0;
         r_prev   <= '0;
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_level  <= '0;
         r_drop   <= '0;
      end else begin
         r_ts <= r_ts + TS_W'(1);
         if (in_valid) begin
            r_prev[spike_id] <= spike_in;
         end
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LVL_W'(1);
            2'b01:   r_level <= r_level - LVL_W'(1);
            default: r_level <= r_level;
         endcase
         if (w_drop && (r_drop != 8'hFF)) begin
            r_drop <= r_drop + 8'd1;
         end
      end
   end

   // Event storage: writes the {id, ts} word at the tail on an accepted push.
   // NOTE: the array has no reset; entries are only read after being written, and level gates validity.
   always_ff @(posedge clk) begin
      if (rst_n && w_push) begin
         r_mem[r_wr_ptr] <= {spike_id, r_ts};
      end
   end

   assign out_valid = ~w_empty;
   assign out_data  = r_mem[r_rd_ptr];
   assign level     = r_level;
   assign drop_cnt  = r_drop;

endmodule

// File: tb/tb_spike_event_queue.sv
// Testbench for spike_event_queue: a driver applies directed and random
// samples, advances an abstract reference model (timestamp, per-ID last
// level, occupancy, drop count) and queues the expected events; a monitor
// compares every handshake and the status outputs against that model.
module tb_spike_event_queue;

   localparam int ID_W  = 2;
   localparam int TS_W  = 8;
   localparam int DEPTH = 8;
   localparam int EV_W  = ID_W + TS_W;
   localparam int LVL_W = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             spike_in = 1'b0;
   logic [ID_W-1:0]  spike_id = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [EV_W-1:0]  out_data;
   logic [LVL_W-1:0] level;
   logic [7:0]       drop_cnt;

   spike_event_queue #(.ID_W(ID_W), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .spike_in  (spike_in),
      .spike_id  (spike_id),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .level     (level),
      .drop_cnt  (drop_cnt)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model state
   int              m_ts;
   bit              m_prev [1 << ID_W];
   int              m_level;
   int              m_drop;
   logic [EV_W-1:0] sb [$];
   bit              mon_en = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Apply one cycle of stimulus and advance the model across the clock edge.
   task automatic step(input bit rst, input bit v, input bit s, input int id, input bit r);
      bit pop;
      bit ev;
      logic [ID_W-1:0] idb;
      logic [TS_W-1:0] tsb;
      rst_n     = ~rst;
      in_valid  = v;
      spike_in  = s;
      idb       = id[ID_W-1:0];
      spike_id  = idb;
      out_ready = r;
      @(posedge clk);
      if (rst) begin
         m_ts    = 0;
         foreach (m_prev[k]) m_prev[k] = 1'b0;
         m_level = 0;
         m_drop  = 0;
         sb.delete();
         mon_en  = 1'b1;
      end else begin
         pop = (m_level > 0) && r;
         ev  = v && s && !m_prev[idb];
         if (v) m_prev[idb] = s;
         if (ev) begin
            if (m_level < DEPTH || pop) begin
               tsb = m_ts[TS_W-1:0];
               sb.push_back({idb, tsb});
               m_level++;
            end else if (m_drop < 255) begin
               m_drop++;
            end
         end
         if (pop) m_level--;
         m_ts = (m_ts + 1) % (1 << TS_W);
      end
      #1;
   endtask

   // Monitor: status every cycle, event words on every handshake.
   always @(negedge clk) begin
      if (mon_en) begin
         check("out_valid", int'(out_valid), int'(m_level != 0));
         check("level", int'(level), m_level);
         check("drop_cnt", int'(drop_cnt), m_drop);
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
               check("unexpected_event", int'(out_data), -1);
            end else begin
               check("event_word", int'(out_data), int'(sb[0]));
               void'(sb.pop_front());
            end
         end
      end
   end

   initial begin
      // Reset and idle long enough for the timestamp to wrap.
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      check("reset_level", int'(level), 0);
      check("reset_valid", int'(out_valid), 0);
      for (int i = 0; i < 300; i++) step(0, 0, 0, 0, $urandom_range(0, 1));

      // Held spike on id 2 from ts=10 gives a single event stamped 10.
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 0);
      step(0, 1, 0, 2, 0);
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 1, 2, 0);
         check("held_level", int'(level), 1);
         check("held_word", int'(out_data), 10'h20A);
      end
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);

      // Round-robin rising edges at ts 4..7 drained immediately.
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) begin
         step(0, 1, 1, i, 1);
         check("rr_visible", int'(out_valid), 1);
         check("rr_word", int'(out_data), (i << TS_W) | (4 + i));
      end
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);

      // Overflow: 10 edges into 8 entries, then push+pop while full.
      step(1, 0, 0, 0, 0);
      for (int k = 0; k < 10; k++) begin
         step(0, 1, 0, k % 4, 0);
         step(0, 1, 1, k % 4, 0);
      end
      check("ovf_level", int'(level), 8);
      check("ovf_drop", int'(drop_cnt), 2);
      step(0, 1, 0, 2, 0);
      step(0, 1, 1, 2, 1);
      check("full_pushpop_level", int'(level), 8);
      check("full_pushpop_drop", int'(drop_cnt), 2);
      for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 1);
      check("ovf_drained", int'(level), 0);

      // Mid-stream reset clears queue and edge history.
      step(1, 0, 0, 0, 0);
      for (int k = 0; k < 5; k++) begin
         step(0, 1, 0, k % 4, 0);
         step(0, 1, 1, k % 4, 0);
      end
      check("pre_rst_level", int'(level), 5);
      step(1, 0, 0, 0, 0);
      check("mid_rst_level", int'(level), 0);
      check("mid_rst_valid", int'(out_valid), 0);
      check("mid_rst_drop", int'(drop_cnt), 0);
      step(0, 1, 1, 1, 0);
      check("post_rst_level", int'(level), 1);
      check("post_rst_word", int'(out_data), 10'h100);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);

      // Drop counter saturation.
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 600; i++) step(0, 1, i % 2, 0, 0);
      check("drop_saturated", int'(drop_cnt), 255);

      // Randomized traffic with occasional resets.
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 4000; i++) begin
         step(($urandom_range(0, 799) == 0),
              ($urandom_range(0, 3) != 0),
              $urandom_range(0, 1),
              $urandom_range(0, 3),
              (((i / 200) % 2) == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
      end
      for (int i = 0; i < 2 * DEPTH; i++) step(0, 0, 0, 0, 1);
      check("final_level", int'(level), 0);
      check("scoreboard_empty", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
